// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'd3 is unused and falls back to IDLE in the decoder.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Ports: d, bout (outputs); a, b, bin (inputs). Purely combinational.
module full_subtractor (
    output logic d,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, D = A - B - BIN, one bit per clock, LSB first.
// Ports: CLK, RST (sync, active-high), START/BUSY/DONE handshake,
//        A, B, BIN operands; D, BOUT, V, Z registered results held until next op.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             V,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw_q;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_next;
    logic             last;

    full_subtractor u_cell (
        .d    (cell_d),
        .bout (cell_bout),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw_q)
    );

    assign res_next = {cell_d, res_sh[WIDTH-1:1]};
    assign last     = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START) state_d = ST_SHIFT;
            ST_SHIFT: if (last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            brw_q   <= 1'b0;
            D       <= '0;
            BOUT    <= 1'b0;
            V       <= 1'b0;
            Z       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        brw_q <= BIN;
                        cnt_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    brw_q  <= cell_bout;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last) begin
                        // On the final bit the shift-register LSBs
                        // hold the operand sign bits.
                        D    <= res_next;
                        BOUT <= cell_bout;
                        V    <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
                        Z    <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor against a plain-arithmetic model.
// Driver pushes expected results; a negedge monitor pops and compares on DONE.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    logic         z;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         v;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] held_d = '0;
    logic         held_bout = 1'b0;
    logic         held_v = 1'b0;
    logic         held_z = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .A     (a),
        .B     (b),
        .BIN   (bin),
        .BUSY  (busy),
        .DONE  (done),
        .D     (d),
        .BOUT  (bout),
        .V     (v),
        .Z     (z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int av, input int bv, input int bi);
        exp_t e;
        int   mask;
        int   r;
        int   sa;
        int   sb;
        int   s;
        mask   = (1 << W) - 1;
        r      = av - bv - bi;
        sa     = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb     = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        s      = sa - sb - bi;
        e.d    = W'(r & mask);
        e.bout = (r < 0);
        e.v    = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        e.z    = ((r & mask) == 0);
        e.cyc  = 0;
        return e;
    endfunction

    // Reset flushes any in-flight expectation and clears held results.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            held_d    = '0;
            held_bout = 1'b0;
            held_v    = 1'b0;
            held_z    = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
            end else begin
                e = q.pop_front();
                chk("d", 32'(d), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("v", 32'(v), 32'(e.v));
                chk("z", 32'(z), 32'(e.z));
                chk("latency_cyc", cyc, e.cyc);
                chk("busy_at_done", 32'(busy), 32'd1);
                held_d    = e.d;
                held_bout = e.bout;
                held_v    = e.v;
                held_z    = e.z;
            end
        end else begin
            chk("hold", {22'd0, d, bout, v, z}, {22'd0, held_d, held_bout, held_v, held_z});
        end
    end

    task automatic issue(input int av, input int bv, input int bi);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle", 32'(busy), 32'd0);
        a     = W'(av);
        b     = W'(bv);
        bin   = bi[0];
        start = 1'b1;
        e     = model(av, bv, bi);
        e.cyc = cyc + 1 + W;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h11;
        bin   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_outs", {23'd0, d, bout, v, z}, 0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        issue(100, 58, 0);
        n = 1;
        while (busy && n < 50) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("busy_len", n, W + 1);
        drain();

        issue(8'h10, 8'h20, 1);
        issue(8'h00, 8'h00, 1);
        issue(8'h80, 8'h01, 0);
        issue(8'h55, 8'h55, 0);
        drain();

        issue(8'h30, 8'h10, 0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("ignored_start", 32'(busy), 0);

        issue(8'hC3, 8'h3C, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_outs", {23'd0, d, bout, v, z}, 0);
        repeat (12) @(negedge clk);
        issue(7, 3, 0);
        drain();
        chk("after_abort_d", 32'(d), 32'h04);

        for (int ai = 0; ai < 32; ai++)
            for (int bi = 0; bi < 32; bi++)
                for (int ci = 0; ci < 2; ci++)
                    issue(ai, bi, ci);
        drain();

        for (int i = 0; i < 300; i++)
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));
        drain();
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
